// File: rtl/census_disparity_wta.sv
// Census stereo correlator: winner-take-all disparity over MAX_DISP candidates.
// Latency: fixed 3 register stages (cost, argmin, output) from the accepting edge.
// Backpressure: none; one pixel per bitvec_val cycle, and gaps of any length are allowed.
//
// Ports: clk/reset (synchronous, active-high); left_bitvec/right_bitvec/bitvec_val/sof in;
//        pixel_x/pixel_y/disparity_val/disparity/min_cost out (held while disparity_val=0).
// Optional: define UNIQ_CHECK_EN to add the disparity_unique output and the UNIQ_MARGIN parameter.
module census_disparity_wta #(
    parameter int BITVEC_W   = 72,
    parameter int MAX_DISP   = 64,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
`ifdef UNIQ_CHECK_EN
    ,
    parameter int UNIQ_MARGIN = 2
`endif
    ,
    localparam int DISP_W = $clog2(MAX_DISP),
    localparam int COST_W = $clog2(BITVEC_W + 1),
    localparam int X_W    = $clog2(IMG_WIDTH),
    localparam int Y_W    = $clog2(IMG_HEIGHT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BITVEC_W-1:0] left_bitvec,
    input  logic [BITVEC_W-1:0] right_bitvec,
    input  logic                bitvec_val,
    input  logic                sof,
    output logic [X_W-1:0]      pixel_x,
    output logic [Y_W-1:0]      pixel_y,
    output logic                disparity_val,
    output logic [DISP_W-1:0]   disparity,
    output logic [COST_W-1:0]   min_cost
`ifdef UNIQ_CHECK_EN
    ,
    output logic                disparity_unique
`endif
);

    // Internal cost width must also hold the saturated "illegal" value BITVEC_W+1.
    localparam int CW = $clog2(BITVEC_W + 2);
    localparam logic [CW-1:0] COST_SAT = CW'(BITVEC_W + 1);

    function automatic logic [CW-1:0] popcnt(input logic [BITVEC_W-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < BITVEC_W; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Coordinates and right-vector history
    // ------------------------------------------------------------------
    logic [X_W-1:0]      x_cnt;
    logic [Y_W-1:0]      y_cnt;
    logic [X_W-1:0]      cur_x;
    logic [Y_W-1:0]      cur_y;
    logic                accept;
    logic [BITVEC_W-1:0] hist_q [1:MAX_DISP-1];
    logic [BITVEC_W-1:0] cand   [MAX_DISP];
    logic [CW-1:0]       cost_c [MAX_DISP];

    assign accept = bitvec_val && !reset;
    // sof overrides whatever the counters say, including a pending wrap.
    assign cur_x  = sof ? '0 : x_cnt;
    assign cur_y  = sof ? '0 : y_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accept) begin
            if (cur_x == X_W'(IMG_WIDTH - 1)) begin
                x_cnt <= '0;
                y_cnt <= (cur_y == Y_W'(IMG_HEIGHT - 1)) ? '0 : cur_y + 1'b1;
            end else begin
                x_cnt <= cur_x + 1'b1;
                y_cnt <= cur_y;
            end
        end
    end

    // History contents need no reset: candidate legality (d <= x) already
    // masks every entry that was not written in the current row.
    always_ff @(posedge clk) begin
        if (accept) begin
            hist_q[1] <= right_bitvec;
            for (int d = 2; d < MAX_DISP; d++) begin
                hist_q[d] <= hist_q[d-1];
            end
        end
    end

    always_comb begin
        cand[0] = right_bitvec;
        for (int d = 1; d < MAX_DISP; d++) begin
            cand[d] = hist_q[d];
        end
        for (int d = 0; d < MAX_DISP; d++) begin
            cost_c[d] = (d <= int'(cur_x)) ? popcnt(left_bitvec ^ cand[d]) : COST_SAT;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-candidate costs
    // ------------------------------------------------------------------
    logic           s1_vld;
    logic [CW-1:0]  s1_cost [MAX_DISP];
    logic [X_W-1:0] s1_x;
    logic [Y_W-1:0] s1_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= bitvec_val;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_cost <= cost_c;
            s1_x    <= cur_x;
            s1_y    <= cur_y;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: argmin (strict < keeps the lowest d on ties)
    // ------------------------------------------------------------------
    logic [CW-1:0]     best_c;
    logic [CW-1:0]     second_c;
    logic [DISP_W-1:0] best_d;

    always_comb begin
        best_c   = COST_SAT;
        second_c = COST_SAT;
        best_d   = '0;
        for (int d = 0; d < MAX_DISP; d++) begin
            if (s1_cost[d] < best_c) begin
                second_c = best_c;
                best_c   = s1_cost[d];
                best_d   = DISP_W'(d);
            end else if (s1_cost[d] < second_c) begin
                second_c = s1_cost[d];
            end
        end
    end

    logic              s2_vld;
    logic [DISP_W-1:0] s2_disp;
    logic [COST_W-1:0] s2_cost;
    logic [X_W-1:0]    s2_x;
    logic [Y_W-1:0]    s2_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
        end
    end

    // d=0 is always legal, so the winner never carries the saturated value.
    always_ff @(posedge clk) begin
        if (s1_vld) begin
            s2_disp <= best_d;
            s2_cost <= best_c[COST_W-1:0];
            s2_x    <= s1_x;
            s2_y    <= s1_y;
        end
    end

`ifdef UNIQ_CHECK_EN
    logic uniq_c;
    logic s2_uniq;

    // A saturated second-best means fewer than two legal candidates.
    assign uniq_c = (second_c == COST_SAT) ||
                    ((int'(second_c) - int'(best_c)) >= UNIQ_MARGIN);

    always_ff @(posedge clk) begin
        if (s1_vld) begin
            s2_uniq <= uniq_c;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage 3: output register, holds while no new result arrives
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            disparity_val <= 1'b0;
            disparity     <= '0;
            min_cost      <= '0;
            pixel_x       <= '0;
            pixel_y       <= '0;
        end else begin
            disparity_val <= s2_vld;
            if (s2_vld) begin
                disparity <= s2_disp;
                min_cost  <= s2_cost;
                pixel_x   <= s2_x;
                pixel_y   <= s2_y;
            end
        end
    end

`ifdef UNIQ_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            disparity_unique <= 1'b0;
        end else if (s2_vld) begin
            disparity_unique <= s2_uniq;
        end
    end
`endif

endmodule
